// File: rtl/spi_ram_pkg.sv
// Shared encodings for the SPI-attached RAM: command codes, FSM states and data width.
package spi_ram_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port RAM: synchronous write, combinational read. Addresses at or beyond
// MEM_DEPTH drop writes and read back as zero.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 CLK,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic              in_range;

    assign in_range = addr_in_range(32'(addr), 32'(MEM_DEPTH));

    always_ff @(posedge CLK) begin
        if (wr_en && in_range) begin
            mem[addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range) begin
            rd_data = mem[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder for the SPI-attached RAM: one command per rx_valid assertion.
// Define SPI_RAM_AUTOINC_EN to post-increment the address after each data access.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [9:0] din,
    output logic       tx_valid,
    output logic [7:0] dout
);

    state_t                state_q, state_d;
    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
    logic                  tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]     dout_q, dout_d;

    logic [1:0]            cmd;
    logic                  exec;
    logic                  mem_wr_en;
    logic [ADDR_SIZE-1:0]  mem_addr;
    logic [DATA_W-1:0]     mem_rd_data;

    assign cmd  = din[9:8];
    // Gated by rst_n so nothing is written to the array while reset is held.
    assign exec = rst_n && (state_q == ST_IDLE) && rx_valid;

    assign mem_wr_en = exec && (cmd == CMD_WR_DATA);
    assign mem_addr  = (cmd == CMD_WR_DATA) ? wr_addr_q : rd_addr_q;

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .CLK     (CLK),
        .wr_en   (mem_wr_en),
        .addr    (mem_addr),
        .wr_data (din[DATA_W-1:0]),
        .rd_data (mem_rd_data)
    );

`ifdef SPI_RAM_AUTOINC_EN
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) >= 32'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return a + ADDR_SIZE'(1);
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        tx_valid_d = 1'b0;
        dout_d     = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    state_d = ST_HOLD;
                    case (cmd)
                        CMD_WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
                        CMD_RD_ADDR: rd_addr_d = din[ADDR_SIZE-1:0];
                        CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                            wr_addr_d = next_addr(wr_addr_q);
`endif
                        end
                        default: begin
                            dout_d     = mem_rd_data;
                            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                            rd_addr_d  = next_addr(rd_addr_q);
`endif
                        end
                    endcase
                end
            end
            default: begin
                if (!rx_valid) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_valid_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tx_valid_q <= tx_valid_d;
            dout_q     <= dout_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign dout     = dout_q;

endmodule
